riscv_hazard_ctrl: RTL and testbench

// - Hazard/stall/flush controller for the 5-stage pipelined RISC-V core (F/D/E/M/W); sits beside data_path, fed by the control_unit/data_path stage fields.
// - Successor to the fixed 2-source forwarding/flush logic: N read ports, load-use stall, branch flush, and wait-state handshakes on the instruction and data memories.
// - Also provides a data-memory timeout monitor and stall/flush performance counters.

---
 rtl/riscv_pipe_pkg.sv | 17 +
 rtl/riscv_fwd_sel.sv | 28 ++
 rtl/riscv_hazard_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_riscv_hazard_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions for the hazard controller: bypass select codes,
// the data-memory wait FSM states and the default register address width.
package riscv_pipe_pkg;

    localparam int REG_AW_DEF = 5;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_TIMEOUT  = 2'b10
    } hz_state_e;

endpackage

// File: rtl/riscv_fwd_sel.sv
// Single-port bypass selector: picks the youngest in-flight writer of one E-stage
// source register, with M taking priority over W and x0 never forwarded.
module riscv_fwd_sel
    import riscv_pipe_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] i_rs_e,
    input  logic [REG_AW-1:0] i_rd_m,
    input  logic [REG_AW-1:0] i_rd_w,
    input  logic              i_reg_write_m,
    input  logic              i_reg_write_w,
    output logic [1:0]        o_fwd
);

    // Bypass source select for this operand
    always_comb begin
        o_fwd = FWD_RF;
        if (i_reg_write_m && (i_rd_m != {REG_AW{1'b0}}) && (i_rd_m == i_rs_e)) begin
            o_fwd = FWD_M;
        end else if (i_reg_write_w && (i_rd_w != {REG_AW{1'b0}}) && (i_rd_w == i_rs_e)) begin
            o_fwd = FWD_W;
        end else begin
            o_fwd = FWD_RF;
        end
    end

endmodule

// File: rtl/riscv_hazard_ctrl.sv
// Hazard controller for the 5-stage core: operand forwarding, prioritised stall/flush
// generation, data-memory wait/timeout tracking and stall/flush performance counters.
module riscv_hazard_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int REG_AW   = REG_AW_DEF,
    parameter int NUM_RP   = 2,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_RP*REG_AW-1:0] i_rs_d,
    input  logic [NUM_RP*REG_AW-1:0] i_rs_e,
    input  logic [REG_AW-1:0]        i_rd_e,
    input  logic [REG_AW-1:0]        i_rd_m,
    input  logic [REG_AW-1:0]        i_rd_w,
    input  logic                     i_load_e,
    input  logic                     i_reg_write_m,
    input  logic                     i_reg_write_w,
    input  logic                     i_pc_src_e,
    input  logic                     i_imem_ready,
    input  logic                     i_dmem_req_m,
    input  logic                     i_dmem_ready,
    output logic [NUM_RP*2-1:0]      o_forward_e,
    output logic                     o_stall_f,
    output logic                     o_stall_d,
    output logic                     o_stall_e,
    output logic                     o_stall_m,
    output logic                     o_flush_d,
    output logic                     o_flush_e,
    output logic                     o_flush_w,
    output logic                     o_mem_timeout,
    output logic [CNT_W-1:0]         o_stall_cnt,
    output logic [CNT_W-1:0]         o_flush_cnt
);

    localparam int          CW    = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] W_MAX = CW'(MAX_WAIT);

    hz_state_e           r_state;
    hz_state_e           w_state_nxt;
    logic [CW-1:0]       r_wcnt;
    logic [CW-1:0]       w_wcnt_nxt;
    logic                w_set_timeout;
    logic                r_mem_timeout;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;
    logic [NUM_RP*2-1:0] w_fwd;
    logic                w_load_use;
    logic                w_dmem_wait;

    assign w_dmem_wait = i_dmem_req_m & ~i_dmem_ready;

    for (genvar g = 0; g < NUM_RP; g++) begin : g_fwd
        riscv_fwd_sel #(.REG_AW(REG_AW)) u_fwd_sel (
            .i_rs_e        (i_rs_e[g*REG_AW +: REG_AW]),
            .i_rd_m        (i_rd_m),
            .i_rd_w        (i_rd_w),
            .i_reg_write_m (i_reg_write_m),
            .i_reg_write_w (i_reg_write_w),
            .o_fwd         (w_fwd[g*2 +: 2])
        );
    end

    // Load in E whose destination is read by any source port of the instruction in D
    always_comb begin
        w_load_use = 1'b0;
        for (int p = 0; p < NUM_RP; p++) begin
            w_load_use = w_load_use | (i_rs_d[p*REG_AW +: REG_AW] == i_rd_e);
        end
        w_load_use = w_load_use & i_load_e & (i_rd_e != {REG_AW{1'b0}});
    end

    // Stall/flush priority: dmem wait > branch > load-use > imem wait
    always_comb begin
        o_stall_f   = 1'b0;
        o_stall_d   = 1'b0;
        o_stall_e   = 1'b0;
        o_stall_m   = 1'b0;
        o_flush_d   = 1'b0;
        o_flush_e   = 1'b0;
        o_flush_w   = 1'b0;
        o_forward_e = w_fwd;
        if (i_rst) begin
            o_flush_d   = 1'b1;
            o_flush_e   = 1'b1;
            o_forward_e = {(NUM_RP*2){1'b0}};
        end else if (w_dmem_wait) begin
            // E is frozen, so a resolved branch stays pending until the access completes
            o_stall_f = 1'b1;
            o_stall_d = 1'b1;
            o_stall_e = 1'b1;
            o_stall_m = 1'b1;
            o_flush_w = 1'b1;
        end else if (i_pc_src_e) begin
            o_flush_d = 1'b1;
            o_flush_e = 1'b1;
        end else if (w_load_use) begin
            o_stall_f = 1'b1;
            o_stall_d = 1'b1;
            o_flush_e = 1'b1;
        end else if (!i_imem_ready) begin
            o_stall_f = 1'b1;
            o_flush_d = 1'b1;
        end else begin
            o_stall_f = 1'b0;
        end
    end

    // Dmem wait FSM next state; counter saturates at MAX_WAIT once timed out
    always_comb begin
        w_state_nxt   = r_state;
        w_wcnt_nxt    = r_wcnt;
        w_set_timeout = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_dmem_wait) begin
                    w_wcnt_nxt = CW'(1);
                    if (W_MAX <= CW'(1)) begin
                        w_state_nxt   = ST_TIMEOUT;
                        w_set_timeout = 1'b1;
                    end else begin
                        w_state_nxt = ST_MEM_WAIT;
                    end
                end else begin
                    w_wcnt_nxt = {CW{1'b0}};
                end
            end
            ST_MEM_WAIT: begin
                if (!w_dmem_wait) begin
                    w_state_nxt = ST_RUN;
                    w_wcnt_nxt  = {CW{1'b0}};
                end else if (r_wcnt + CW'(1) >= W_MAX) begin
                    w_state_nxt   = ST_TIMEOUT;
                    w_wcnt_nxt    = W_MAX;
                    w_set_timeout = 1'b1;
                end else begin
                    w_wcnt_nxt = r_wcnt + CW'(1);
                end
            end
            ST_TIMEOUT: begin
                if (!w_dmem_wait) begin
                    w_state_nxt = ST_RUN;
                    w_wcnt_nxt  = {CW{1'b0}};
                end else begin
                    w_state_nxt = ST_TIMEOUT;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_wcnt_nxt  = {CW{1'b0}};
            end
        endcase
    end

    // FSM, sticky timeout and saturating performance counters
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= ST_RUN;
            r_wcnt        <= {CW{1'b0}};
            r_mem_timeout <= 1'b0;
            r_stall_cnt   <= {CNT_W{1'b0}};
            r_flush_cnt   <= {CNT_W{1'b0}};
        end else begin
            r_state       <= w_state_nxt;
            r_wcnt        <= w_wcnt_nxt;
            r_mem_timeout <= r_mem_timeout | w_set_timeout;
            if (o_stall_f && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (o_flush_e && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end
        end
    end

    assign o_mem_timeout = r_mem_timeout;
    assign o_stall_cnt   = r_stall_cnt;
    assign o_flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Bench for riscv_hazard_ctrl: directed vectors with literal expectations plus a
// cycle-by-cycle comparison against a behavioural model of the hazard rules.
module tb_riscv_hazard_ctrl;

    localparam int REG_AW   = 5;
    localparam int NUM_RP   = 2;
    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 5;
    localparam int SAT      = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    logic [REG_AW-1:0] rs_d [NUM_RP];
    logic [REG_AW-1:0] rs_e [NUM_RP];
    logic [NUM_RP*REG_AW-1:0] rs_d_flat, rs_e_flat;
    logic [REG_AW-1:0] rd_e, rd_m, rd_w;
    logic load_e, reg_write_m, reg_write_w, pc_src_e, imem_ready, dmem_req_m, dmem_ready;
    logic [NUM_RP*2-1:0] forward_e;
    logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always_comb begin
        rs_d_flat = '0;
        rs_e_flat = '0;
        for (int p = 0; p < NUM_RP; p++) begin
            rs_d_flat[p*REG_AW +: REG_AW] = rs_d[p];
            rs_e_flat[p*REG_AW +: REG_AW] = rs_e[p];
        end
    end

    riscv_hazard_ctrl #(.REG_AW(REG_AW), .NUM_RP(NUM_RP), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst(rst), .i_rs_d(rs_d_flat), .i_rs_e(rs_e_flat),
        .i_rd_e(rd_e), .i_rd_m(rd_m), .i_rd_w(rd_w), .i_load_e(load_e),
        .i_reg_write_m(reg_write_m), .i_reg_write_w(reg_write_w), .i_pc_src_e(pc_src_e),
        .i_imem_ready(imem_ready), .i_dmem_req_m(dmem_req_m), .i_dmem_ready(dmem_ready),
        .o_forward_e(forward_e), .o_stall_f(stall_f), .o_stall_d(stall_d),
        .o_stall_e(stall_e), .o_stall_m(stall_m), .o_flush_d(flush_d), .o_flush_e(flush_e),
        .o_flush_w(flush_w), .o_mem_timeout(mem_timeout),
        .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed { logic sf, sd, se, sm, fd, fe, fw; } ctl_t;

    function automatic ctl_t model_ctl();
        ctl_t c;
        logic lu;
        c  = '0;
        lu = 1'b0;
        for (int p = 0; p < NUM_RP; p++)
            if (load_e && rd_e != 0 && rs_d[p] == rd_e) lu = 1'b1;
        if (rst) begin
            c.fd = 1'b1; c.fe = 1'b1;
        end else if (dmem_req_m && !dmem_ready) begin
            c.sf = 1'b1; c.sd = 1'b1; c.se = 1'b1; c.sm = 1'b1; c.fw = 1'b1;
        end else if (pc_src_e) begin
            c.fd = 1'b1; c.fe = 1'b1;
        end else begin
            if (lu) begin c.sf = 1'b1; c.sd = 1'b1; c.fe = 1'b1; end
            if (!imem_ready) begin c.sf = 1'b1; c.fd = !lu; end
        end
        return c;
    endfunction

    function automatic logic [1:0] model_fwd(input logic [REG_AW-1:0] rs);
        if (rst) return 2'b00;
        if (reg_write_m && rd_m != 0 && rd_m == rs) return 2'b10;
        if (reg_write_w && rd_w != 0 && rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    ctl_t m_ctl;
    int   m_wait_run, m_scnt, m_fcnt;
    logic m_timeout;

    always_comb m_ctl = model_ctl();

    // Model state: consecutive wait cycles, sticky timeout, saturating counts
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_wait_run <= 0; m_timeout <= 1'b0; m_scnt <= 0; m_fcnt <= 0;
        end else begin
            if (dmem_req_m && !dmem_ready) begin
                m_wait_run <= m_wait_run + 1;
                if (m_wait_run + 1 >= MAX_WAIT) m_timeout <= 1'b1;
            end else begin
                m_wait_run <= 0;
            end
            if (m_ctl.sf && m_scnt < SAT) m_scnt <= m_scnt + 1;
            if (m_ctl.fe && m_fcnt < SAT) m_fcnt <= m_fcnt + 1;
        end
    end

    // Compare DUT against the model every cycle, away from the active edge
    always @(negedge clk) begin
        chk("ctl", {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}, m_ctl);
        chk("fwd", forward_e, {model_fwd(rs_e[1]), model_fwd(rs_e[0])});
        chk("timeout", mem_timeout, rst ? 1'b0 : m_timeout);
        chk("stall_cnt", stall_cnt, rst ? 0 : m_scnt);
        chk("flush_cnt", flush_cnt, rst ? 0 : m_fcnt);
    end

    // ---------------- directed stimulus ----------------
    task automatic nxt(); @(posedge clk); #1; endtask
    task automatic mid(); @(negedge clk); #1; endtask

    task automatic clear();
        for (int p = 0; p < NUM_RP; p++) begin rs_d[p] = '0; rs_e[p] = '0; end
        rd_e = '0; rd_m = '0; rd_w = '0;
        load_e = 1'b0; reg_write_m = 1'b0; reg_write_w = 1'b0; pc_src_e = 1'b0;
        imem_ready = 1'b1; dmem_req_m = 1'b0; dmem_ready = 1'b0;
    endtask

    int c0;

    initial begin
        rst = 1'b1;
        clear();
        mid();
        chk("rst_flush_de", {flush_d, flush_e}, 2'b11);
        chk("rst_stalls", {stall_f, stall_d, stall_e, stall_m}, 4'b0000);
        chk("rst_fwd_cnt", {forward_e, stall_cnt, flush_cnt, mem_timeout}, '0);
        nxt(); rst = 1'b0;

        // forwarding
        reg_write_m = 1'b1; rd_m = 5'd5; reg_write_w = 1'b1; rd_w = 5'd5; rs_e[0] = 5'd5;
        mid(); chk("fwd_m", forward_e[1:0], 2'b10);
        nxt(); rd_m = 5'd0;
        mid(); chk("fwd_w", forward_e[1:0], 2'b01);
        nxt(); rd_w = 5'd0;
        mid(); chk("fwd_rf", forward_e[1:0], 2'b00);
        nxt(); reg_write_m = 1'b0; rd_m = 5'd9; rd_w = 5'd9; rs_e[1] = 5'd9;
        mid(); chk("fwd_p1_w", forward_e, 4'b0100);

        // load-use and its interaction with branch / imem wait
        nxt(); clear(); load_e = 1'b1; rd_e = 5'd7; rs_d[1] = 5'd7;
        mid(); chk("lu", {stall_f, stall_d, flush_e, flush_d}, 4'b1110);
        nxt(); pc_src_e = 1'b1;
        mid(); chk("lu_br", {flush_d, flush_e, stall_f, stall_d}, 4'b1100);
        nxt(); pc_src_e = 1'b0; rd_e = 5'd0; rs_d[1] = 5'd0;
        mid(); chk("lu_x0", {stall_f, flush_e}, 2'b00);
        nxt(); rd_e = 5'd7; rs_d[1] = 5'd7; imem_ready = 1'b0;
        mid(); chk("lu_imem", {stall_f, stall_d, flush_e, flush_d}, 4'b1110);

        // imem wait
        nxt(); clear();
        mid(); c0 = stall_cnt;
        nxt(); imem_ready = 1'b0;
        mid(); chk("imem1", {stall_f, flush_d}, 2'b11);
        nxt();
        mid(); chk("imem2", {stall_f, flush_d}, 2'b11);
        nxt(); imem_ready = 1'b1;
        mid(); chk("imem_cnt", stall_cnt, c0 + 2);

        // dmem wait with a pending branch
        nxt(); dmem_req_m = 1'b1; dmem_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            if (k == 3) pc_src_e = 1'b1;
            mid(); chk("dmem_hold", {stall_f, stall_d, stall_e, stall_m, flush_w, flush_d, flush_e}, 7'b1111100);
            nxt();
        end
        dmem_ready = 1'b1;
        mid(); chk("dmem_rel", {flush_d, flush_e, stall_f, stall_m, mem_timeout}, 5'b11000);
        nxt(); clear();
        mid(); chk("no_to_3", mem_timeout, 1'b0);

        // timeout after MAX_WAIT consecutive wait cycles
        nxt(); dmem_req_m = 1'b1; dmem_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            mid(); chk("to_seq", mem_timeout, (k >= 5) ? 1'b1 : 1'b0);
            nxt();
        end
        dmem_ready = 1'b1;
        mid(); chk("to_rel", {mem_timeout, stall_f}, 2'b10);
        nxt(); clear();
        mid(); chk("to_sticky", mem_timeout, 1'b1);

        // reset in the middle of a dmem wait
        nxt(); dmem_req_m = 1'b1;
        nxt(); nxt(); rst = 1'b1;
        mid(); chk("mrst", {flush_d, flush_e, stall_f, mem_timeout}, 4'b1100);
        chk("mrst_cnt", {stall_cnt, flush_cnt}, '0);
        nxt(); rst = 1'b0; clear();

        // counter saturation
        imem_ready = 1'b0;
        repeat (40) nxt();
        imem_ready = 1'b1;
        mid(); chk("sat", stall_cnt, SAT);

        // randomised traffic checked by the model
        nxt(); rst = 1'b1;
        nxt(); rst = 1'b0;
        for (int n = 0; n < 300; n++) begin
            for (int p = 0; p < NUM_RP; p++) begin
                rs_d[p] = REG_AW'($urandom_range(0, 3));
                rs_e[p] = REG_AW'($urandom_range(0, 3));
            end
            rd_e = REG_AW'($urandom_range(0, 3));
            rd_m = REG_AW'($urandom_range(0, 3));
            rd_w = REG_AW'($urandom_range(0, 3));
            load_e      = 1'($urandom_range(0, 1));
            reg_write_m = 1'($urandom_range(0, 1));
            reg_write_w = 1'($urandom_range(0, 1));
            pc_src_e    = ($urandom_range(0, 3) == 0);
            imem_ready  = ($urandom_range(0, 3) != 0);
            dmem_req_m  = ($urandom_range(0, 2) == 0);
            dmem_ready  = 1'($urandom_range(0, 1));
            nxt();
        end

        mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
